rx_scan_sequencer: RTL and testbench

Line-by-line scan controller for the ultrasound receive chain, clocked on clk_100M. For each scan line it fires the transmit pulse, waits out the transducer dead time, opens the ADC capture window, and writes samples into the line buffer. It then hands the buffer to the Trans_Data readout path through a req/done handshake and holds the pulse repetition period before the next line. It sits between the system control registers and the receive datapath that produces Trans_Data.

---
 rtl/rx_scan_sequencer.sv | 99 +++++++++
 tb/tb_rx_scan_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/rx_scan_sequencer.sv
// rx_scan_sequencer: per-line fire/dead/capture/transfer/PRF-gap controller for the receive chain
module rx_scan_sequencer #(
    parameter int LINE_NUM   = 128,
    parameter int SAMPLE_NUM = 2048,
    parameter int FIRE_CYC   = 4,
    parameter int DEAD_CYC   = 200,
    parameter int PRF_CYC    = 20000
) (
    input  logic                          clk_100M,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic                          stop,
    input  logic                          cont,
    input  logic                          xfer_done,
    output logic                          tx_fire,
    output logic                          adc_en,
    output logic                          wr_en,
    output logic [$clog2(SAMPLE_NUM)-1:0] wr_addr,
    output logic [$clog2(LINE_NUM)-1:0]   line_idx,
    output logic                          xfer_req,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          prf_overrun
);
    localparam int AW = $clog2(SAMPLE_NUM);
    localparam int LW = $clog2(LINE_NUM);
    localparam int CW = $clog2((FIRE_CYC > DEAD_CYC ? FIRE_CYC : DEAD_CYC) + 1);

    typedef enum logic [2:0] {IDLE, FIRE, DEAD, CAPTURE, XFER, GAP} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic [23:0]   prf_cnt;
    logic          stop_pend, gap_first;
    logic          halt, last_line, prf_met, gap_exit;

    assign halt      = stop_pend | stop;
    assign last_line = line_idx == LW'(LINE_NUM - 1);
    assign prf_met   = prf_cnt >= 24'(PRF_CYC - 1);
    assign gap_exit  = state == GAP && prf_met;

    // next-state decode; a stop in the GAP exit cycle counts as pending
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start && !stop) state_nx = FIRE;
            FIRE:    if (cnt == CW'(FIRE_CYC - 1)) state_nx = DEAD;
            DEAD:    if (cnt == CW'(DEAD_CYC - 1)) state_nx = CAPTURE;
            CAPTURE: if (wr_addr == AW'(SAMPLE_NUM - 1)) state_nx = XFER;
            XFER:    if (xfer_done) state_nx = GAP;
            GAP:     if (prf_met) state_nx = (last_line ? (cont && !halt) : !halt) ? FIRE : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // state register, phase counters, line index and sticky flags
    always_ff @(posedge clk_100M or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            wr_addr     <= '0;
            prf_cnt     <= '0;
            gap_first   <= 1'b0;
            stop_pend   <= 1'b0;
            line_idx    <= '0;
            prf_overrun <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= (state_nx == state && (state == FIRE || state == DEAD)) ? cnt + 1'b1 : '0;
            wr_addr     <= (state == CAPTURE && state_nx == CAPTURE) ? wr_addr + 1'b1 : '0;
            prf_cnt     <= (state_nx == FIRE && state != FIRE) ? '0 :
                           (state != IDLE && prf_cnt != '1) ? prf_cnt + 1'b1 : prf_cnt;
            gap_first   <= state_nx == GAP && state != GAP;
            stop_pend   <= state_nx != IDLE && (stop_pend || (stop && state != IDLE));
            line_idx    <= gap_exit ? ((last_line || halt) ? '0 : line_idx + 1'b1) : line_idx;
            prf_overrun <= (state == IDLE && state_nx == FIRE) ? 1'b0 :
                           prf_overrun | (state == GAP && gap_first && prf_met);
        end
    end

    // outputs registered from the upcoming state so they track the state register exactly
    always_ff @(posedge clk_100M or negedge reset_n) begin
        if (!reset_n) begin
            tx_fire    <= 1'b0;
            adc_en     <= 1'b0;
            wr_en      <= 1'b0;
            xfer_req   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            tx_fire    <= state_nx == FIRE;
            adc_en     <= state_nx == CAPTURE;
            wr_en      <= state_nx == CAPTURE;
            xfer_req   <= state_nx == XFER;
            busy       <= state_nx != IDLE;
            frame_done <= gap_exit && last_line;
        end
    end
endmodule

// File: tb/tb_rx_scan_sequencer.sv
// tb_rx_scan_sequencer: randomized bench checking the scan sequencer against a line-timeline model
module tb_rx_scan_sequencer;
    localparam int LN   = 4;
    localparam int SN   = 8;
    localparam int FC   = 2;
    localparam int DC   = 3;
    localparam int PRF  = 40;
    localparam int CAP0 = FC + DC;
    localparam int REQ0 = FC + DC + SN;
    localparam int BIG  = 1 << 30;

    logic       clk_100M = 1'b0, reset_n = 1'b0;
    logic       start = 1'b0, stop = 1'b0, cont = 1'b0, xfer_done = 1'b0;
    logic       tx_fire, adc_en, wr_en, xfer_req, busy, frame_done, prf_overrun;
    logic [2:0] wr_addr;
    logic [1:0] line_idx;

    rx_scan_sequencer #(
        .LINE_NUM(LN), .SAMPLE_NUM(SN), .FIRE_CYC(FC), .DEAD_CYC(DC), .PRF_CYC(PRF)
    ) dut (
        .clk_100M(clk_100M), .reset_n(reset_n), .start(start), .stop(stop), .cont(cont),
        .xfer_done(xfer_done), .tx_fire(tx_fire), .adc_en(adc_en), .wr_en(wr_en),
        .wr_addr(wr_addr), .line_idx(line_idx), .xfer_req(xfer_req), .busy(busy),
        .frame_done(frame_done), .prf_overrun(prf_overrun)
    );

    always #5 clk_100M = ~clk_100M;

    int total = 0, bad = 0, cyc = 0;
    // model: each line is a timeline anchored at its fire cycle f; n is the cycle after its GAP
    bit act, kick, pend, ovr, ovr_line, rnd, spur;
    int line, f, d, n, fd, dly, fd_obs, t0, k;
    int dly_set[LN];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_tx_fire"}, tx_fire, 0);
        chk({tag, "_adc_en"}, adc_en, 0);
        chk({tag, "_wr_en"}, wr_en, 0);
        chk({tag, "_wr_addr"}, wr_addr, 0);
        chk({tag, "_line_idx"}, line_idx, 0);
        chk({tag, "_xfer_req"}, xfer_req, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_prf_overrun"}, prf_overrun, 0);
    endtask

    task automatic model_reset();
        act = 0; kick = 0; pend = 0; ovr = 0; ovr_line = 0;
        line = 0; d = -1; n = BIG; fd = -1;
    endtask

    task automatic new_line(input int c);
        f = c; d = -1; n = BIG; ovr_line = 0;
        dly = rnd ? ($urandom_range(0, 3) == 0 ? $urandom_range(20, 45) : $urandom_range(0, 10))
                  : dly_set[line];
    endtask

    task automatic step();
        bit go, ea;
        @(posedge clk_100M);
        #1;
        cyc++;
        if (cyc == n) begin
            if (kick) begin
                kick = 0; act = 1; ovr = 0; line = 0;
                new_line(cyc);
            end else begin
                ovr = ovr | ovr_line;
                if (line == LN - 1) begin
                    fd = cyc; line = 0; go = cont && !pend;
                end else if (pend) begin
                    line = 0; go = 0;
                end else begin
                    line++; go = 1;
                end
                if (go) new_line(cyc);
                else begin act = 0; pend = 0; n = BIG; end
            end
        end
        ea = act && cyc >= f + CAP0 && cyc < f + REQ0;
        chk("tx_fire", tx_fire, act && cyc < f + FC);
        chk("adc_en", adc_en, ea);
        chk("wr_en", wr_en, ea);
        chk("wr_addr", wr_addr, ea ? cyc - f - CAP0 : 0);
        chk("xfer_req", xfer_req, act && cyc >= f + REQ0 && (d < 0 || cyc <= d));
        chk("busy", busy, act);
        chk("line_idx", line_idx, line);
        chk("frame_done", frame_done, cyc == fd);
        chk("prf_overrun", prf_overrun, ovr);
        if (frame_done === 1'b1) fd_obs = cyc;
        start = 0; stop = 0; xfer_done = 0;
        if (act && d < 0 && cyc == f + REQ0 + dly) begin
            xfer_done = 1;
            d = cyc;
            ovr_line = (d + 1 - f) >= PRF - 1;
            n = ovr_line ? d + 2 : f + PRF;
        end else if (spur && $urandom_range(0, 7) == 0 && !(act && d < 0 && cyc >= f + REQ0))
            xfer_done = 1;
    endtask

    task automatic drv(input bit st, input bit sp);
        start = st;
        stop  = sp;
        if (sp && act) pend = 1;
        if (st && !sp && !act && !kick) begin kick = 1; n = cyc + 1; end
    endtask

    task automatic run_idle(input int max);
        int j = 0;
        while ((act || kick) && j < max) begin step(); j++; end
        chk("idle_busy", busy, 0);
    endtask

    task automatic do_reset();
        start = 0; stop = 0; xfer_done = 0;
        #2 reset_n = 0;
        #1 chk_zero("async_rst");
        model_reset();
        @(negedge clk_100M);
        reset_n = 1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        rnd = 0; spur = 0; fd_obs = -1;
        foreach (dly_set[i]) dly_set[i] = 5;
        repeat (3) @(posedge clk_100M);
        #1 chk_zero("reset");
        @(negedge clk_100M);
        reset_n = 1;
        step(); step();
        // single frame, fixed transfer latency
        step(); t0 = cyc; drv(1, 0);
        run_idle(400);
        chk("t1_frame_done_at", fd_obs, t0 + 161);
        // late transfer on line 1 forces an overrun
        dly_set[1] = 40;
        step(); drv(1, 0);
        run_idle(400);
        chk("t2_overrun_sticky", prf_overrun, 1);
        dly_set[1] = 5;
        // stop during line 1 capture
        step(); drv(1, 0);
        k = 0;
        while (!(act && line == 1 && cyc == f + CAP0 + 2) && k < 200) begin step(); k++; end
        drv(0, 1);
        fd_obs = -1;
        run_idle(200);
        chk("t3_no_frame_done", fd_obs, -1);
        spur = 1;
        repeat (30) step();
        spur = 0;
        // continuous frames with ignored starts while busy
        cont = 1;
        step(); drv(1, 0);
        repeat (260) begin step(); drv($urandom_range(0, 3) == 0, 0); end
        cont = 0;
        run_idle(200);
        // start and stop together in IDLE
        step(); drv(1, 1);
        repeat (3) step();
        chk("t5_busy", busy, 0);
        // reset in the middle of capture
        step(); drv(1, 0);
        k = 0;
        while (!(act && cyc == f + CAP0 + 4) && k < 50) begin step(); k++; end
        chk("t6_wr_addr_pre", wr_addr, 4);
        do_reset();
        step(); drv(1, 0);
        run_idle(400);
        // randomized traffic
        rnd = 1; spur = 1;
        for (int i = 0; i < 3000; i++) begin
            step();
            if ($urandom_range(0, 199) == 0) cont = ~cont;
            drv($urandom_range(0, 15) == 0, $urandom_range(0, 99) == 0);
            if (i == 1500) do_reset();
        end
        rnd = 0; spur = 0; cont = 0;
        run_idle(400);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
